// File: rtl/bus_xfer_seq_if.sv
// Request/bus bundle for bus_xfer_seq.
// slave = transfer sequencer, master = control unit / register file side.
interface bus_xfer_seq_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4,
  parameter int NDST  = 16
) ();
  localparam int NSRC = 2**SEL_W;

  logic [WIDTH*NSRC-1:0] src_flat;
  logic [NSRC-1:0]       src_present;
  logic                  req_valid;
  logic                  req_ready;
  logic [SEL_W-1:0]      req_src;
  logic [NDST-1:0]       req_dst;
  logic [WIDTH-1:0]      bus_data;
  logic [NDST-1:0]       dst_load;
  logic                  done;
  logic                  err;

  modport slave (
    input  src_flat,
    input  src_present,
    input  req_valid,
    input  req_src,
    input  req_dst,
    output req_ready,
    output bus_data,
    output dst_load,
    output done,
    output err
  );

  modport master (
    output src_flat,
    output src_present,
    output req_valid,
    output req_src,
    output req_dst,
    input  req_ready,
    input  bus_data,
    input  dst_load,
    input  done,
    input  err
  );
endinterface

// File: rtl/bus_xfer_seq.sv
// Registered register-to-register transfer sequencer (IDLE/SAMPLE/DRIVE).
// Optional macro BUS_SRC_CHECK_EN rejects unpopulated source slots with err.
module bus_xfer_seq #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4,
  parameter int NDST  = 16
) (
  input logic         clk,
  input logic         rst,
  bus_xfer_seq_if.slave bus
);
  localparam int NSRC = 2**SEL_W;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    DRIVE
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [NDST-1:0]  dst_q, dst_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic [WIDTH-1:0] src_word;
  logic             drive;

`ifdef BUS_SRC_CHECK_EN
  logic err_q, err_d;
  logic src_ok;
  assign src_ok = bus.src_present[src_q];
`else
  logic unused_present;
  assign unused_present = ^bus.src_present;
`endif

  always_comb begin
    src_word = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (src_q == SEL_W'(k))
        src_word = bus.src_flat[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    bus_d   = bus_q;
`ifdef BUS_SRC_CHECK_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          src_d   = bus.req_src;
          dst_d   = bus.req_dst;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
`ifdef BUS_SRC_CHECK_EN
        if (src_ok) begin
          bus_d   = src_word;
          state_d = DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`else
        bus_d   = src_word;
        state_d = DRIVE;
`endif
      end
      DRIVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      bus_q   <= '0;
`ifdef BUS_SRC_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      bus_q   <= bus_d;
`ifdef BUS_SRC_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Gate with rst so a reset landing in DRIVE never loads a destination.
  assign drive         = (state_q == DRIVE) && !rst;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.bus_data  = bus_q;
  assign bus.dst_load  = drive ? dst_q : '0;
  assign bus.done      = drive;
`ifdef BUS_SRC_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_bus_xfer_seq.sv
// Self-checking bench for bus_xfer_seq: vector table, hand sequences,
// and randomized transfers against a transaction-level model.
module tb_bus_xfer_seq;
  localparam int W  = 16;
  localparam int S  = 4;
  localparam int N  = 16;
  localparam int NS = 16;
`ifdef BUS_SRC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_xfer_seq_if #(.WIDTH(W), .SEL_W(S), .NDST(N)) bif ();

  bus_xfer_seq #(.WIDTH(W), .SEL_W(S), .NDST(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  logic [W-1:0]  mem [NS];
  logic [NS-1:0] pres;
  logic [W-1:0]  model_bus;
  int            tests = 0;
  int            fails = 0;

  always_comb begin
    bif.src_flat = '0;
    for (int k = 0; k < NS; k++)
      bif.src_flat[k*W +: W] = mem[k];
  end
  assign bif.src_present = pres;

  typedef struct {
    logic [S-1:0] s;
    logic [N-1:0] d;
    logic [W-1:0] data;
    logic [W-1:0] exp_bus;
    logic [N-1:0] exp_dst;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [S-1:0] s, input logic [N-1:0] d,
                      input logic [W-1:0] exp_bus,
                      input logic [N-1:0] exp_dst, input bit bad);
    chk("idle_ready", 32'(bif.req_ready), 32'd1);
    bif.req_valid = 1'b1;
    bif.req_src   = s;
    bif.req_dst   = d;
    tick();
    bif.req_valid = 1'b0;
    bif.req_src   = ~s;
    bif.req_dst   = ~d;
    chk("sample_ready", 32'(bif.req_ready), 32'd0);
    chk("sample_done", 32'(bif.done), 32'd0);
    chk("sample_dst", 32'(bif.dst_load), 32'd0);
    tick();
    chk("bus_data", 32'(bif.bus_data), 32'(exp_bus));
    if (bad) begin
      chk("rej_err", 32'(bif.err), 32'd1);
      chk("rej_done", 32'(bif.done), 32'd0);
      chk("rej_dst", 32'(bif.dst_load), 32'd0);
      chk("rej_ready", 32'(bif.req_ready), 32'd1);
    end else begin
      chk("drv_done", 32'(bif.done), 32'd1);
      chk("drv_dst", 32'(bif.dst_load), 32'(exp_dst));
      chk("drv_err", 32'(bif.err), 32'd0);
      chk("drv_ready", 32'(bif.req_ready), 32'd0);
    end
    tick();
    chk("post_done", 32'(bif.done), 32'd0);
    chk("post_dst", 32'(bif.dst_load), 32'd0);
    chk("post_err", 32'(bif.err), 32'd0);
    chk("post_ready", 32'(bif.req_ready), 32'd1);
    chk("post_bus", 32'(bif.bus_data), 32'(exp_bus));
    model_bus = exp_bus;
  endtask

  initial begin
    vecs[0] = '{4'd9,  16'h0004, 16'hA5C3, 16'hA5C3, 16'h0004};
    vecs[1] = '{4'd4,  16'h00C1, 16'h5A5A, 16'h5A5A, 16'h00C1};
    vecs[2] = '{4'd5,  16'h0000, 16'h7777, 16'h7777, 16'h0000};
    vecs[3] = '{4'd15, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{4'd0,  16'h8000, 16'h0000, 16'h0000, 16'h8000};
    vecs[5] = '{4'd7,  16'h0080, 16'h0F0F, 16'h0F0F, 16'h0080};

    for (int k = 0; k < NS; k++) mem[k] = '0;
    pres          = '1;
    model_bus     = '0;
    bif.req_valid = 1'b0;
    bif.req_src   = '0;
    bif.req_dst   = '0;

    // req_valid during reset must be ignored
    rst = 1'b1;
    bif.req_valid = 1'b1;
    bif.req_src   = 4'd1;
    tick();
    tick();
    chk("rst_ready", 32'(bif.req_ready), 32'd1);
    chk("rst_bus", 32'(bif.bus_data), 32'd0);
    chk("rst_dst", 32'(bif.dst_load), 32'd0);
    chk("rst_done", 32'(bif.done), 32'd0);
    chk("rst_err", 32'(bif.err), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_accept", 32'(bif.req_ready), 32'd0);
    bif.req_valid = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", 32'(bif.req_ready), 32'd1);
    model_bus = mem[1];

    for (int i = 0; i < 6; i++) begin
      mem[vecs[i].s] = vecs[i].data;
      xfer(vecs[i].s, vecs[i].d, vecs[i].exp_bus, vecs[i].exp_dst, 1'b0);
    end

    // back-to-back with req_valid held high
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    bif.req_valid = 1'b1;
    bif.req_src   = 4'd0;
    bif.req_dst   = 16'h0002;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) bif.req_src = 4'(i + 1);
      else bif.req_valid = 1'b0;
      chk("b2b_sample_ready", 32'(bif.req_ready), 32'd0);
      tick();
      chk("b2b_bus", 32'(bif.bus_data), 32'(mem[i]));
      chk("b2b_done", 32'(bif.done), 32'd1);
      tick();
      chk("b2b_idle_ready", 32'(bif.req_ready), 32'd1);
      chk("b2b_idle_done", 32'(bif.done), 32'd0);
      if (i < 2) tick();
    end
    model_bus = mem[2];

    // source changes between accept and SAMPLE edge
    mem[3] = 16'h0001;
    bif.req_valid = 1'b1;
    bif.req_src   = 4'd3;
    bif.req_dst   = 16'h0010;
    tick();
    bif.req_valid = 1'b0;
    mem[3] = 16'h0002;
    tick();
    chk("late_src_bus", 32'(bif.bus_data), 32'h0002);
    chk("late_src_dst", 32'(bif.dst_load), 32'h0010);
    tick();
    model_bus = 16'h0002;

    // reset during DRIVE
    mem[6] = 16'hCAFE;
    bif.req_valid = 1'b1;
    bif.req_src   = 4'd6;
    bif.req_dst   = 16'h0040;
    tick();
    bif.req_valid = 1'b0;
    tick();
    chk("pre_rst_bus", 32'(bif.bus_data), 32'hCAFE);
    rst = 1'b1;
    #1;
    chk("rst_in_drive_done", 32'(bif.done), 32'd0);
    chk("rst_in_drive_dst", 32'(bif.dst_load), 32'd0);
    tick();
    rst = 1'b0;
    chk("after_rst_bus", 32'(bif.bus_data), 32'd0);
    chk("after_rst_dst", 32'(bif.dst_load), 32'd0);
    chk("after_rst_done", 32'(bif.done), 32'd0);
    chk("after_rst_ready", 32'(bif.req_ready), 32'd1);
    model_bus = '0;

    // unpopulated source slot
    mem[0] = 16'h1234;
    mem[8] = 16'hBEEF;
    xfer(4'd0, 16'h0001, 16'h1234, 16'h0001, 1'b0);
    pres[8] = 1'b0;
    if (CHK) xfer(4'd8, 16'h0002, 16'h1234, 16'h0002, 1'b1);
    else xfer(4'd8, 16'h0002, 16'hBEEF, 16'h0002, 1'b0);
    pres = '1;

    // randomized transfers against the transaction model
    for (int i = 0; i < 40; i++) begin
      logic [S-1:0] s;
      logic [N-1:0] d;
      bit           bad;
      mem[$urandom_range(0, NS-1)] = W'($urandom);
      mem[$urandom_range(0, NS-1)] = W'($urandom);
      pres = NS'($urandom) | NS'($urandom);
      s    = S'($urandom_range(0, NS-1));
      d    = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      bad  = CHK && !pres[s];
      xfer(s, d, bad ? model_bus : mem[s], d, bad);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
